// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared command codes, request opcodes, bus words, encoder
//               states and beat-word builder for the UART command encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Command field (io_out7[1:0]) values understood by the target
    localparam logic [1:0] CMD_DATA   = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_PREDIV = 2'd2;
    localparam logic [1:0] CMD_SPARE  = 2'd3;

    // CONFIG payload that the target interprets as a soft reset
    localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

    // Host request opcodes
    localparam logic [1:0] OP_DATA   = 2'd0;
    localparam logic [1:0] OP_CONFIG = 2'd1;
    localparam logic [1:0] OP_PREDIV = 2'd2;
    localparam logic [1:0] OP_RESET  = 2'd3;

    // Idle bus word: spare command with a zero payload
    localparam logic [6:0] NOP_WORD = {5'd0, CMD_SPARE};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BEAT0  = 3'd1,
        GAP0   = 3'd2,
        BEAT1  = 3'd3,
        GAP1   = 3'd4,
        SETTLE = 3'd5
    } enc_state_t;

    // Two-beat requests carry a full byte split into low/high nibbles
    function automatic logic is_two_beat(input logic [1:0] op);
        return (op == OP_DATA) || (op == OP_PREDIV);
    endfunction

    // Bus word for beat 0 (high == 0) or beat 1 (high == 1) of a request
    function automatic logic [6:0] beat_word(input logic [1:0] op,
                                             input logic [7:0] data,
                                             input logic       high);
        logic [1:0] cmd;
        logic [4:0] payload;
        cmd     = CMD_SPARE;
        payload = 5'd0;
        case (op)
            OP_DATA, OP_PREDIV: begin
                cmd     = (op == OP_DATA) ? CMD_DATA : CMD_PREDIV;
                payload = high ? {1'b1, data[7:4]} : {1'b0, data[3:0]};
            end
            OP_CONFIG: begin
                cmd     = CMD_CONFIG;
                payload = data[4:0];
            end
            default: begin
                cmd     = CMD_CONFIG;
                payload = CMD_CONFIG_RESET;
            end
        endcase
        return {payload, cmd};
    endfunction

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/uart_cmd_beat_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_beat_timer
// Description : 8-bit loadable down-counter. expire is high during the last
//               cycle of a loaded count, so a load of N spans N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_beat_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       expire
);

    logic [7:0] r_count;

    // Load on request, otherwise count down and rest at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    // A count of one is the final cycle; zero is treated as already expired
    assign expire = (r_count <= 8'd1);

endmodule : uart_cmd_beat_timer
`default_nettype wire

// File: rtl/uart_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_encoder
// Description : Accepts host requests on a valid/ready handshake and emits
//               them as timed command beats on the target's 7-bit bus.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_encoder
    import uart_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2,
    parameter int GAP_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic [6:0] io_out7,
    output logic       busy,
    output logic       done_strobe
);

    localparam logic [7:0] c_hold   = 8'(HOLD_CYCLES);
    localparam logic [7:0] c_gap    = 8'(GAP_CYCLES);
    localparam logic [7:0] c_settle = 8'(SETTLE_CYCLES);

    enc_state_t r_state;
    enc_state_t w_state_next;
    logic [1:0] r_op;
    logic [7:0] r_data;
    logic [6:0] r_io_out7;
    logic       r_done;
    logic       w_accept;
    logic       w_load;
    logic [7:0] w_load_value;
    logic       w_expire;
    logic [1:0] w_op;
    logic [7:0] w_data;
    logic [6:0] w_word_next;

    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign io_out7     = r_io_out7;
    assign done_strobe = r_done;
    assign w_accept    = req_valid && req_ready;

    // On the accept edge the latched copy is not yet valid, so the first
    // beat word is built from the live request fields
    assign w_op   = w_accept ? req_op   : r_op;
    assign w_data = w_accept ? req_data : r_data;

    uart_cmd_beat_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .expire     (w_expire)
    );

    // State register and request latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op    <= OP_DATA;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op   <= req_op;
                r_data <= req_data;
            end
        end
    end

    // Next-state and timer-load decisions
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_value = 8'd0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = BEAT0;
                    w_load       = 1'b1;
                    w_load_value = c_hold;
                end
            end
            BEAT0: begin
                if (w_expire) begin
                    w_state_next = GAP0;
                    w_load       = 1'b1;
                    w_load_value = c_gap;
                end
            end
            GAP0: begin
                if (w_expire) begin
                    if (is_two_beat(r_op)) begin
                        w_state_next = BEAT1;
                        w_load       = 1'b1;
                        w_load_value = c_hold;
                    end else if ((r_op == OP_RESET) && (c_settle != 8'd0)) begin
                        w_state_next = SETTLE;
                        w_load       = 1'b1;
                        w_load_value = c_settle;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            BEAT1: begin
                if (w_expire) begin
                    w_state_next = GAP1;
                    w_load       = 1'b1;
                    w_load_value = c_gap;
                end
            end
            GAP1, SETTLE: begin
                if (w_expire) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bus word for the state being entered, so io_out7 can be registered
    always_comb begin
        w_word_next = NOP_WORD;
        case (w_state_next)
            BEAT0:   w_word_next = beat_word(w_op, w_data, 1'b0);
            BEAT1:   w_word_next = beat_word(w_op, w_data, 1'b1);
            default: w_word_next = NOP_WORD;
        endcase
    end

    // Registered bus output and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_io_out7 <= NOP_WORD;
            r_done    <= 1'b0;
        end else begin
            r_io_out7 <= w_word_next;
            r_done    <= (r_state != IDLE) && (w_state_next == IDLE);
        end
    end

endmodule : uart_cmd_encoder
`default_nettype wire

// File: tb/tb_uart_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_encoder
// Description : Self-checking bench for uart_cmd_encoder: directed table,
//               back-to-back and reset corner cases, random requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_encoder;

    localparam int HOLD   = 2;
    localparam int GAP    = 1;
    localparam int SETTLE = 8;
    localparam logic [6:0] NOP = 7'b0000011;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [6:0] io_out7;
    logic       busy;
    logic       done_strobe;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [6:0] w0;
        logic [6:0] w1;   // NOP for single-beat requests
        int         lat;  // accept edge to done_strobe, in cycles
    } vec_t;

    vec_t vecs[6];

    uart_cmd_encoder #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .io_out7     (io_out7),
        .busy        (busy),
        .done_strobe (done_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got out7=%b busy/done/ready=%b expected out7=%b busy/done/ready=%b",
                     name, act[9:3], act[2:0], expv[9:3], expv[2:0]);
        end
    endtask

    function automatic logic [9:0] obs();
        return {io_out7, busy, done_strobe, req_ready};
    endfunction

    // Reference model: list the beats a request produces, then lay them out
    // in time as HOLD copies followed by GAP NOPs, plus settle NOPs on reset
    task automatic model_expect(input logic [1:0] op, input logic [7:0] data);
        int beats[$];
        int cmd;
        exp_q.delete();
        case (op)
            2'd0, 2'd2: begin
                cmd = (op == 2'd0) ? 0 : 2;
                beats.push_back((int'(data) % 16) * 4 + cmd);
                beats.push_back((16 + int'(data) / 16) * 4 + cmd);
            end
            2'd1:    beats.push_back((int'(data) % 32) * 4 + 1);
            default: beats.push_back(24 * 4 + 1);
        endcase
        foreach (beats[b]) begin
            for (int h = 0; h < HOLD; h++) exp_q.push_back(7'(beats[b]));
            for (int g = 0; g < GAP; g++)  exp_q.push_back(NOP);
        end
        if (op == 2'd3)
            for (int s = 0; s < SETTLE; s++) exp_q.push_back(NOP);
    endtask

    // Expected stream from a table row: beats, gaps, then NOP padding up to
    // the tabulated latency
    task automatic table_expect(input vec_t v);
        exp_q.delete();
        for (int h = 0; h < HOLD; h++) exp_q.push_back(v.w0);
        for (int g = 0; g < GAP; g++)  exp_q.push_back(NOP);
        if (v.w1 != NOP) begin
            for (int h = 0; h < HOLD; h++) exp_q.push_back(v.w1);
            for (int g = 0; g < GAP; g++)  exp_q.push_back(NOP);
        end
        while (exp_q.size() < v.lat - 1) exp_q.push_back(NOP);
    endtask

    // Issue one request (called #1 after a clock edge) and check every cycle
    // up to and including the done_strobe cycle against exp_q. After accept
    // the inputs are either scrambled or set up for the next request.
    task automatic run_req(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input bit hold_next, input logic [1:0] nop, input logic [7:0] ndata);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        chk({tag, "/ready"}, {7'd0, 2'b00, req_ready}, {7'd0, 2'b00, 1'b1});
        @(posedge clk); #1;
        if (hold_next) begin
            req_valid = 1'b1;
            req_op    = nop;
            req_data  = ndata;
        end else begin
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_data  = 8'($urandom);
        end
        foreach (exp_q[i]) begin
            chk($sformatf("%s/cyc%0d", tag, i + 1), obs(), {exp_q[i], 3'b100});
            @(posedge clk); #1;
        end
        chk({tag, "/done"}, obs(), {NOP, 3'b011});
    endtask

    initial begin
        vecs[0] = '{op: 2'd0, data: 8'hA5, w0: 7'b0_0101_00, w1: 7'b1_1010_00, lat: 7};
        vecs[1] = '{op: 2'd2, data: 8'h3C, w0: 7'b0_1100_10, w1: 7'b1_0011_10, lat: 7};
        vecs[2] = '{op: 2'd1, data: 8'h7F, w0: 7'b11111_01,  w1: NOP,          lat: 4};
        vecs[3] = '{op: 2'd3, data: 8'hFF, w0: 7'b11000_01,  w1: NOP,          lat: 12};
        vecs[4] = '{op: 2'd1, data: 8'hF8, w0: 7'b11000_01,  w1: NOP,          lat: 4};
        vecs[5] = '{op: 2'd0, data: 8'h00, w0: 7'b0_0000_00, w1: 7'b1_0000_00, lat: 7};

        // Reset: idle outputs, and a request held during reset is ignored
        reset     = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/idle", obs(), {NOP, 3'b001});
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset/after_release", obs(), {NOP, 3'b001});

        // Directed table
        foreach (vecs[k]) begin
            table_expect(vecs[k]);
            run_req($sformatf("vec%0d", k), vecs[k].op, vecs[k].data, 1'b0, 2'd0, 8'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d/idle", k), obs(), {NOP, 3'b001});
        end

        // Back-to-back: valid stays high, data changes mid-request
        model_expect(2'd0, 8'h12);
        run_req("b2b_first", 2'd0, 8'h12, 1'b1, 2'd2, 8'h9E);
        model_expect(2'd2, 8'h9E);
        run_req("b2b_second", 2'd2, 8'h9E, 1'b0, 2'd0, 8'd0);

        // Reset asserted during the high beat
        @(posedge clk); #1;
        model_expect(2'd0, 8'h5A);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_data  = 8'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst/beat1", obs(), {exp_q[3], 3'b100});
        #2;
        reset     = 1'b0;
        req_valid = 1'b1;
        #1;
        chk("midrst/async", obs(), {NOP, 3'b001});
        @(posedge clk); #1;
        chk("midrst/held", obs(), {NOP, 3'b001});
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst/released", obs(), {NOP, 3'b001});
        model_expect(2'd0, 8'hC3);
        run_req("midrst/rerun", 2'd0, 8'hC3, 1'b0, 2'd0, 8'd0);

        // Random requests with random idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [7:0] data;
            int         gap;
            op   = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            gap  = $urandom_range(0, 2);
            model_expect(op, data);
            run_req($sformatf("rnd%0d_op%0d_%02h", n, op, data), op, data, 1'b0, 2'd0, 8'd0);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d/gap%0d", n, g), obs(), {NOP, 3'b001});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_cmd_encoder
`default_nettype wire
